// File: rtl/viterbi_chan_err_inj.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | viterbi_chan_err_inj                                                        |
// | Channel corruption stage between the convolutional encoder and the Viterbi  |
// | decoder. Each symbol is registered and can be corrupted with burst and/or   |
// | LFSR-driven single-bit errors. Symbols and injected bit errors are counted  |
// | for BER scoring. Optional feature macro: CHAN_INJ_CLEAR_EN (adds clear_i).  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module viterbi_chan_err_inj #(
  parameter int               W      = 2,
  parameter int               N      = 5,
  parameter int               BURST  = 4,
  parameter int               WINDOW = 256,
  parameter int               LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter logic [LFSR_W-1:0] TAPS  = 16'hB400
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CHAN_INJ_CLEAR_EN
  input  logic              clear_i,
`endif
  input  logic [1:0]        mode_i,
  input  logic [LFSR_W-1:0] ber_thresh_i,
  input  logic              valid_i,
  input  logic [W-1:0]      sym_i,
  output logic              valid_o,
  output logic [W-1:0]      sym_o,
  output logic [W-1:0]      clean_o,
  output logic [W-1:0]      err_mask_o,
  output logic [31:0]       sym_ct_o,
  output logic [31:0]       bit_err_ct_o,
  output logic              window_done_o
);

  localparam int          c_PERIOD      = 1 << N;
  localparam int          c_IDX_W       = (W > 1) ? $clog2(W) : 1;
  localparam int          c_POP_W       = $clog2(W + 1);
  localparam logic [N:0]  c_BURST_START = (N+1)'(c_PERIOD - BURST);
  localparam logic [31:0] c_WINDOW      = 32'(WINDOW);

  logic              r_valid;
  logic [W-1:0]      r_sym;
  logic [W-1:0]      r_clean;
  logic [W-1:0]      r_mask;
  logic [31:0]       r_sym_ct;
  logic [31:0]       r_bit_err_ct;
  logic              r_done;
  logic [LFSR_W-1:0] r_lfsr;
  logic [c_IDX_W-1:0] r_idx;

  logic              w_clear;
  logic              w_in_win;
  logic [N:0]        w_phase;
  logic              w_burst_hit;
  logic              w_rand_hit;
  logic [W-1:0]      w_mask;
  logic [c_POP_W-1:0] w_pop;
  logic [32:0]       w_err_sum;
  logic [31:0]       w_err_next;
  logic [31:0]       w_sym_next;
  logic [c_IDX_W-1:0] w_idx_next;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic              w_done_next;

`ifdef CHAN_INJ_CLEAR_EN
  assign w_clear = clear_i;
`else
  assign w_clear = 1'b0;
`endif

  // Window and burst phase are judged on the count before this symbol is added.
  assign w_in_win    = (WINDOW == 0) || (r_sym_ct < c_WINDOW);
  assign w_phase     = {1'b0, r_sym_ct[N-1:0]};
  assign w_burst_hit = mode_i[0] && w_in_win && (w_phase >= c_BURST_START);
  assign w_rand_hit  = mode_i[1] && w_in_win && (r_lfsr <= ber_thresh_i);

  always_comb begin
    w_mask = '0;
    if (!w_clear) begin
      if (w_rand_hit)
        w_mask = W'(1) << r_idx;
      if (w_burst_hit)
        w_mask = '1;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++)
      w_pop = w_pop + c_POP_W'(w_mask[i]);
  end

  assign w_err_sum   = {1'b0, r_bit_err_ct} + 33'(w_pop);
  assign w_err_next  = w_err_sum[32] ? '1 : w_err_sum[31:0];
  assign w_sym_next  = (r_sym_ct == '1) ? r_sym_ct : r_sym_ct + 32'd1;
  assign w_idx_next  = (r_idx == c_IDX_W'(W - 1)) ? '0 : r_idx + c_IDX_W'(1);
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_done_next = (WINDOW != 0) && (w_sym_next >= c_WINDOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_sym        <= '0;
      r_clean      <= '0;
      r_mask       <= '0;
      r_sym_ct     <= '0;
      r_bit_err_ct <= '0;
      r_done       <= 1'b0;
      r_lfsr       <= SEED;
      r_idx        <= '0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_sym   <= sym_i ^ w_mask;
        r_clean <= sym_i;
        r_mask  <= w_mask;
      end
      if (w_clear) begin
        r_sym_ct     <= '0;
        r_bit_err_ct <= '0;
        r_done       <= 1'b0;
        r_lfsr       <= SEED;
        r_idx        <= '0;
      end else if (valid_i) begin
        r_sym_ct     <= w_sym_next;
        r_bit_err_ct <= w_err_next;
        r_idx        <= w_idx_next;
        if (w_done_next)
          r_done <= 1'b1;
        if (mode_i[1] && w_in_win)
          r_lfsr <= w_lfsr_next;
      end
    end
  end

  assign valid_o       = r_valid;
  assign sym_o         = r_sym;
  assign clean_o       = r_clean;
  assign err_mask_o    = r_mask;
  assign sym_ct_o      = r_sym_ct;
  assign bit_err_ct_o  = r_bit_err_ct;
  assign window_done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_chan_err_inj.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_viterbi_chan_err_inj                                                     |
// | Directed bench with a behavioural channel model and per-cycle comparison.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_viterbi_chan_err_inj;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [15:0] ber_thresh_i = 16'd0;
  logic        valid_i = 1'b0;
  logic [1:0]  sym_i = 2'd0;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic [1:0]  clean_o;
  logic [1:0]  err_mask_o;
  logic [31:0] sym_ct_o;
  logic [31:0] bit_err_ct_o;
  logic        window_done_o;

  int n_vec = 0;
  int n_err = 0;

  viterbi_chan_err_inj dut (
    .clk           (clk),
    .rst           (rst),
`ifdef CHAN_INJ_CLEAR_EN
    .clear_i       (1'b0),
`endif
    .mode_i        (mode_i),
    .ber_thresh_i  (ber_thresh_i),
    .valid_i       (valid_i),
    .sym_i         (sym_i),
    .valid_o       (valid_o),
    .sym_o         (sym_o),
    .clean_o       (clean_o),
    .err_mask_o    (err_mask_o),
    .sym_ct_o      (sym_ct_o),
    .bit_err_ct_o  (bit_err_ct_o),
    .window_done_o (window_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural channel model: integer symbol count, period arithmetic, 16-bit Galois LFSR.
  longint      m_cnt  = 0;
  longint      m_err  = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_idx  = 0;
  logic        e_valid = 1'b0;
  logic [1:0]  e_sym = 2'd0, e_clean = 2'd0, e_mask = 2'd0;

  always @(posedge clk or negedge rst) begin
    logic [1:0] mask;
    logic       in_win;
    if (!rst) begin
      m_cnt = 0; m_err = 0; m_lfsr = 16'hACE1; m_idx = 0;
      e_valid = 1'b0; e_sym = 2'd0; e_clean = 2'd0; e_mask = 2'd0;
    end else begin
      e_valid = valid_i;
      if (valid_i) begin
        in_win = (m_cnt < 256);
        mask = 2'b00;
        if (mode_i[1] && in_win) begin
          if (m_lfsr <= ber_thresh_i) mask = (m_idx == 0) ? 2'b01 : 2'b10;
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        if (mode_i[0] && in_win && (m_cnt % 32) >= 28) mask = 2'b11;
        m_err = m_err + $countones(mask);
        if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_idx = (m_idx + 1) % 2;
        e_sym = sym_i ^ mask; e_clean = sym_i; e_mask = mask;
      end
    end
  end

  always @(negedge clk) begin
    check("valid_o",     {31'd0, valid_o},       {31'd0, e_valid});
    check("sym_o",       {30'd0, sym_o},         {30'd0, e_sym});
    check("clean_o",     {30'd0, clean_o},       {30'd0, e_clean});
    check("err_mask_o",  {30'd0, err_mask_o},    {30'd0, e_mask});
    check("sym_ct_o",    sym_ct_o,               32'(m_cnt));
    check("bit_err_ct",  bit_err_ct_o,           32'(m_err));
    check("window_done", {31'd0, window_done_o}, {31'd0, (m_cnt >= 256)});
  end

  task automatic drive(input logic v, input logic [1:0] s);
    @(posedge clk); #2;
    valid_i = v; sym_i = s;
  endtask

  task automatic send_n(input int n, input logic [1:0] s);
    for (int i = 0; i < n; i++) drive(1'b1, s);
  endtask

  // Let the last driven symbol be captured, then land on the next sampling point.
  task automatic settle();
    drive(1'b0, sym_i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0; valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("lit_reset_sym_ct", sym_ct_o, 32'd0);
    check("lit_reset_sym_o", {30'd0, sym_o}, 32'd0);
    do_reset();

    // Off mode: transparent channel past the window.
    mode_i = 2'd0;
    send_n(300, 2'b10);
    settle();
    check("lit_off_sym_ct", sym_ct_o, 32'd300);
    check("lit_off_err", bit_err_ct_o, 32'd0);
    check("lit_off_sym_o", {30'd0, sym_o}, 32'd2);
    check("lit_off_done", {31'd0, window_done_o}, 32'd1);

    // Burst mode: symbols 28..31 of every 32 inverted, window of 256.
    do_reset();
    mode_i = 2'd1;
    send_n(28, 2'b00);
    settle();
    check("lit_burst_err28", bit_err_ct_o, 32'd0);
    check("lit_burst_sym27", {30'd0, sym_o}, 32'd0);
    send_n(1, 2'b00);
    settle();
    check("lit_burst_sym28", {30'd0, sym_o}, 32'd3);
    send_n(3, 2'b00);
    settle();
    check("lit_burst_err32", bit_err_ct_o, 32'd8);
    send_n(223, 2'b00);
    settle();
    check("lit_burst_done255", {31'd0, window_done_o}, 32'd0);
    send_n(1, 2'b00);
    settle();
    check("lit_burst_done256", {31'd0, window_done_o}, 32'd1);
    check("lit_burst_err256", bit_err_ct_o, 32'd64);
    send_n(44, 2'b00);
    settle();
    check("lit_burst_err300", bit_err_ct_o, 32'd64);
    check("lit_burst_sym299", {30'd0, sym_o}, 32'd0);

    // Random mode: threshold 0 never fires, all-ones fires on every symbol.
    do_reset();
    mode_i = 2'd2; ber_thresh_i = 16'h0000;
    send_n(20, 2'b00);
    settle();
    check("lit_rand0_err", bit_err_ct_o, 32'd0);
    ber_thresh_i = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      send_n(1, 2'b00);
      settle();
      check("lit_randff_mask", {30'd0, err_mask_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    check("lit_randff_err", bit_err_ct_o, 32'd4);

    // Gapped strobes: outputs and counters hold across idle cycles.
    do_reset();
    mode_i = 2'd1;
    for (int i = 0; i < 40; i++) drive(i[0] == 1'b0, 2'(i));
    settle();
    check("lit_gap_sym_ct", sym_ct_o, 32'd20);

    // Reset in the middle of a burst, then the channel restarts clean.
    do_reset();
    mode_i = 2'd1;
    send_n(30, 2'b01);
    do_reset();
    send_n(10, 2'b01);
    settle();
    check("lit_rst_err", bit_err_ct_o, 32'd0);
    check("lit_rst_sym_ct", sym_ct_o, 32'd10);
    check("lit_rst_sym_o", {30'd0, sym_o}, 32'd1);

    // Combined modes with a mid-range threshold and varied data.
    do_reset();
    mode_i = 2'd3; ber_thresh_i = 16'h8000;
    for (int i = 0; i < 100; i++) drive(1'b1, 2'($urandom_range(0, 3)));
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
